board_io_conditioner: RTL
=========================

Name: board_io_conditioner

Overview:
- Parametrised board-I/O front end for the FPGA targets. Sits between raw board pins (buttons, switches, LEDs) and the SoC pad/GPIO signals.
- Input side: N asynchronous inputs are synchronised and debounced, then produce clean levels plus rise/fall strobes.
- Output side: M LED outputs are driven with glitch-free PWM brightness control, replacing the direct one-pin-per-signal LED/switch mapping.

Parameters:
- NUM_IN, 7, number of debounced input channels (>=1).
- NUM_LED, 4, number of PWM LED channels (>=1).
- DEBOUNCE_CYCLES, 1000, consecutive stable cycles required to accept a new input level (>=1).
- PWM_WIDTH, 8, PWM counter/duty width in bits; period is 2^PWM_WIDTH cycles (2..16).

Ports:
- clk_i  in  1  single system clock.
- rst_i  in  1  reset, synchronous, active-high.
- pad_in_i  in  NUM_IN  raw asynchronous board inputs.
- in_level_o  out  NUM_IN  debounced level per channel.
- in_rise_o  out  NUM_IN  1-cycle strobe when the debounced level goes 0->1.
- in_fall_o  out  NUM_IN  1-cycle strobe when the debounced level goes 1->0.
- led_duty_i  in  NUM_LED*PWM_WIDTH  duty per LED; channel i is bits [i*PWM_WIDTH +: PWM_WIDTH].
- led_en_i  in  NUM_LED  per-LED enable.
- led_o  out  NUM_LED  PWM LED drive, registered.
- pwm_period_end_o  out  1  strobe in the last cycle of each PWM period.

Behaviour:
- Reset: one clock; reset is synchronous and active-high (rst_i sampled on the clk_i rising edge).
  - Synchroniser flops, debounced levels, debounce counters, PWM counter, latched duties, led_o and all strobes clear to 0.
  - Reset asserted mid-debounce or mid-period discards all progress.
  - A channel whose pad is 1 at reset release reports in_rise_o after the normal debounce latency.
- Synchroniser: 2-flop per channel (sync1 <= pad_in_i, sync2 <= sync1). No combinational path from pad_in_i to any output.
- Debounce, per channel, counter width clog2(DEBOUNCE_CYCLES+1):
  - If sync2 == level, the counter is set to 0.
  - Else, if counter == DEBOUNCE_CYCLES-1: level <= sync2, counter <= 0, and the matching rise/fall strobe is high for the next cycle only.
  - Else, counter increments.
  - Any bounce back to the current level before acceptance restarts the count from 0.
- Debounce latency: a clean step first sampled at edge t appears on in_level_o after edge t+DEBOUNCE_CYCLES+1 (DEBOUNCE_CYCLES+2 edges inclusive).
  - The strobe is asserted in the same cycle the level changes. Rise and fall are never both high on one channel.
- PWM counter: free-running cnt of PWM_WIDTH bits, 0..2^PWM_WIDTH-1, wraps to 0.
  - pwm_period_end_o = (cnt == max), registered so it is aligned with the cycle in which cnt == max.
- Duty latch: per LED, duty_q <= led_duty_i slice on the edge where cnt wraps max->0. A duty change mid-period takes effect at the next period start, so there are no partial-period glitches.
- LED drive: led_o[i] registered each cycle.
  - duty_q == all-ones: led_o[i] = led_en_i[i], constantly on.
  - Otherwise: led_o[i] = led_en_i[i] & (cnt < duty_q).
  - duty_q == 0 gives constantly off.
  - led_en_i acts immediately, with 1 cycle of register latency and no period alignment.
- Duty edge cases:
  - On-time per period equals duty_q cycles for 0 < duty_q < max.
  - The first period after reset uses duty 0, so LEDs stay dark until the first wrap.

Test Plan:
- DEBOUNCE_CYCLES=4: pad_in_i[0] steps 0->1 before edge 0 and is held -> in_level_o[0]=1 after edge 5; in_rise_o[0] high exactly one cycle (after edge 5); in_fall_o[0] stays 0.
- DEBOUNCE_CYCLES=4: pad pulses 1 for 3 cycles, then 0 -> in_level_o stays 0 and no strobes; next a 1 held for 4+ sync cycles -> accepted with the full latency counted from the last bounce.
- All NUM_IN channels toggled simultaneously 1->0 after stable 1 -> every in_fall_o bit high in the same single cycle; in_rise_o all 0.
- PWM_WIDTH=4, led_en_i=1, duty=5 -> after the first wrap, led_o high 5 of every 16 cycles, starting the cycle after cnt=0; pwm_period_end_o pulses every 16 cycles.
  - duty=0 -> led_o always 0. duty=15 -> led_o always 1.
- PWM_WIDTH=4, duty changed 5->10 at cnt=7 -> current period keeps 5 on-cycles; the next period has 10. Dropping led_en_i mid-period -> led_o 0 one cycle later.
- rst_i asserted for 1 cycle mid-debounce (counter=2) and mid-PWM (cnt=9) -> all outputs 0 the next cycle; cnt restarts at 0; the held pad input re-qualifies with the full DEBOUNCE_CYCLES+2 latency.

Source files
------------

// File: rtl/board_io_conditioner.sv
// Board I/O front end: synchronised, debounced inputs with edge strobes, and
// period-aligned PWM brightness control for LED outputs.
module board_io_conditioner #(
  parameter int NUM_IN          = 7,
  parameter int NUM_LED         = 4,
  parameter int DEBOUNCE_CYCLES = 1000,
  parameter int PWM_WIDTH       = 8
) (
  input  logic                           clk_i,
  input  logic                           rst_i,
  input  logic [NUM_IN-1:0]              pad_in_i,
  output logic [NUM_IN-1:0]              in_level_o,
  output logic [NUM_IN-1:0]              in_rise_o,
  output logic [NUM_IN-1:0]              in_fall_o,
  input  logic [NUM_LED*PWM_WIDTH-1:0]   led_duty_i,
  input  logic [NUM_LED-1:0]             led_en_i,
  output logic [NUM_LED-1:0]             led_o,
  output logic                           pwm_period_end_o
);

  localparam int DB_W = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [DB_W-1:0]      DB_LAST  = DB_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [DB_W-1:0]      DB_ONE   = DB_W'(1);
  localparam logic [PWM_WIDTH-1:0] PWM_MAX  = '1;
  localparam logic [PWM_WIDTH-1:0] PWM_PRE  = PWM_MAX - PWM_WIDTH'(1);
  localparam logic [PWM_WIDTH-1:0] PWM_ONE  = PWM_WIDTH'(1);

  // ---------------------------------------------------------------------
  // Input side
  // ---------------------------------------------------------------------
  logic [NUM_IN-1:0] sync1;
  logic [NUM_IN-1:0] sync2;
  logic [NUM_IN-1:0] level_q;
  logic [NUM_IN-1:0] rise_q;
  logic [NUM_IN-1:0] fall_q;
  logic [DB_W-1:0]   db_cnt [NUM_IN];

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      sync1 <= '0;
      sync2 <= '0;
    end else begin
      sync1 <= pad_in_i;
      sync2 <= sync1;
    end
  end

  // The counter only runs while the synchronised input disagrees with the
  // accepted level, so any bounce back restarts qualification from zero.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      level_q <= '0;
      rise_q  <= '0;
      fall_q  <= '0;
      for (int i = 0; i < NUM_IN; i++) begin
        db_cnt[i] <= '0;
      end
    end else begin
      for (int i = 0; i < NUM_IN; i++) begin
        rise_q[i] <= 1'b0;
        fall_q[i] <= 1'b0;
        if (sync2[i] == level_q[i]) begin
          db_cnt[i] <= '0;
        end else if (db_cnt[i] == DB_LAST) begin
          level_q[i] <= sync2[i];
          db_cnt[i]  <= '0;
          rise_q[i]  <= sync2[i];
          fall_q[i]  <= ~sync2[i];
        end else begin
          db_cnt[i] <= db_cnt[i] + DB_ONE;
        end
      end
    end
  end

  assign in_level_o = level_q;
  assign in_rise_o  = rise_q;
  assign in_fall_o  = fall_q;

  // ---------------------------------------------------------------------
  // Output side
  // ---------------------------------------------------------------------
  logic [PWM_WIDTH-1:0] pwm_cnt;
  logic                 period_end_q;
  logic [PWM_WIDTH-1:0] duty_q [NUM_LED];
  logic [NUM_LED-1:0]   led_q;
  logic                 wrap;

  assign wrap = (pwm_cnt == PWM_MAX);

  // period_end_q is loaded one cycle early so it is high while pwm_cnt == max.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      pwm_cnt      <= '0;
      period_end_q <= 1'b0;
    end else begin
      pwm_cnt      <= pwm_cnt + PWM_ONE;
      period_end_q <= (pwm_cnt == PWM_PRE);
    end
  end

  // Duties are only sampled at the period boundary so a mid-period change
  // never produces a partial pulse.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      for (int i = 0; i < NUM_LED; i++) begin
        duty_q[i] <= '0;
      end
    end else if (wrap) begin
      for (int i = 0; i < NUM_LED; i++) begin
        duty_q[i] <= led_duty_i[i*PWM_WIDTH +: PWM_WIDTH];
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      led_q <= '0;
    end else begin
      for (int i = 0; i < NUM_LED; i++) begin
        led_q[i] <= led_en_i[i] & ((duty_q[i] == PWM_MAX) | (pwm_cnt < duty_q[i]));
      end
    end
  end

  assign led_o            = led_q;
  assign pwm_period_end_o = period_end_q;

endmodule
